// File: rtl/bcd_pkg.sv
// Shared types and constants for the priority-to-BCD encoder: digit type,
// error codes and the largest index two BCD digits can represent.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_NONE  = 2'b01,
        ERR_MULTI = 2'b10
    } err_code_t;

    localparam int unsigned BCD_MAX_IDX = 99;

    function automatic logic [7:0] pack_bcd(input bcd_digit_t tens, input bcd_digit_t units);
        return {tens, units};
    endfunction

endpackage

// File: rtl/priority_bcd_encoder_bin2bcd_2dig.sv
// Combinational 7-bit binary to two-digit BCD converter; inputs above 99
// saturate to 99 so both digits always stay in 0..9.
module bin2bcd_2dig
    import bcd_pkg::*;
(
    input  logic [6:0] bin_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t units_o
);

    logic [6:0] bin_s;
    bcd_digit_t tens_s;
    bcd_digit_t units_s;

    // Clamp, then pick the tens digit by threshold compares instead of a divider
    always_comb begin
        if (bin_i > 7'(BCD_MAX_IDX)) begin
            bin_s = 7'(BCD_MAX_IDX);
        end else begin
            bin_s = bin_i;
        end
        tens_s = 4'd0;
        for (int t = 1; t < 10; t++) begin
            if (bin_s >= 7'(10 * t)) begin
                tens_s = 4'(t);
            end else begin
                tens_s = tens_s;
            end
        end
        units_s = 4'(bin_s - (7'(tens_s) * 7'd10));
    end

    assign tens_o  = tens_s;
    assign units_o = units_s;

endmodule

// File: rtl/priority_bcd_encoder.sv
// Two-stage priority encoder with BCD output and valid/ready flow control.
// Optional saturating error counter enabled by macro PRIORITY_BCD_ERR_CNT_EN.
module priority_bcd_encoder
    import bcd_pkg::*;
#(
    parameter  int N_IN      = 10,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int IDX_W     = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   in_d,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [7:0]        out_bcd,
    output logic [1:0]        out_err,
    output logic              out_valid,
`ifdef PRIORITY_BCD_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    input  logic              out_ready
);

    localparam logic [N_IN-1:0] ZERO_V = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] ONE_V  = {{(N_IN-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] enc_idx_s;
    err_code_t        enc_err_s;
    logic             s2_adv_s;
    bcd_digit_t       tens_s;
    bcd_digit_t       units_s;

    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_idx_q,   s1_idx_d;
    err_code_t        s1_err_q,   s1_err_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q,   out_idx_d;
    logic [7:0]       out_bcd_q,   out_bcd_d;
    err_code_t        out_err_q,   out_err_d;

    // Priority select: the last match in scan order wins
    always_comb begin
        enc_idx_s = {IDX_W{1'b0}};
        if (MSB_FIRST) begin
            for (int k = 0; k < N_IN; k++) begin
                if (in_d[k]) begin
                    enc_idx_s = IDX_W'(k);
                end else begin
                    enc_idx_s = enc_idx_s;
                end
            end
        end else begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                if (in_d[k]) begin
                    enc_idx_s = IDX_W'(k);
                end else begin
                    enc_idx_s = enc_idx_s;
                end
            end
        end
        if (in_d == ZERO_V) begin
            enc_err_s = ERR_NONE;
        end else if ((in_d & (in_d - ONE_V)) != ZERO_V) begin
            enc_err_s = ERR_MULTI;
        end else begin
            enc_err_s = ERR_OK;
        end
    end

    bin2bcd_2dig u_bin2bcd (
        .bin_i   (7'(s1_idx_q)),
        .tens_o  (tens_s),
        .units_o (units_s)
    );

    assign s2_adv_s = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv_s;

    // Next-state for both stages; stage 1 refills in the cycle it drains
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_idx_d    = s1_idx_q;
        s1_err_d    = s1_err_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_bcd_d   = out_bcd_q;
        out_err_d   = out_err_q;
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_idx_d = s1_idx_q;
                out_bcd_d = pack_bcd(tens_s, units_s);
                out_err_d = s1_err_q;
            end else begin
                out_idx_d = out_idx_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_idx_d = enc_idx_s;
                s1_err_d = enc_err_s;
            end else begin
                s1_idx_d = s1_idx_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= {IDX_W{1'b0}};
            s1_err_q    <= ERR_OK;
            out_valid_q <= 1'b0;
            out_idx_q   <= {IDX_W{1'b0}};
            out_bcd_q   <= 8'h00;
            out_err_q   <= ERR_OK;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_bcd_q   <= out_bcd_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_bcd   = out_bcd_q;
    assign out_err   = out_err_q;

`ifdef PRIORITY_BCD_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count error results as they leave, saturating at 255
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_valid_q && out_ready && (out_err_q != ERR_OK) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_priority_bcd_encoder.sv
// Self-checking bench: three encoder instances (N=10 LSB-first, N=10 MSB-first,
// N=64 LSB-first) driven in lockstep, checked by directed tables and a scoreboard.
module tb_priority_bcd_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [9:0]  in_d10 = 10'd0;
    logic [63:0] in_d64 = 64'd0;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic [3:0]  idx_a, idx_b;
    logic [5:0]  idx_c;
    logic [7:0]  bcd_a, bcd_b, bcd_c;
    logic [1:0]  err_a, err_b, err_c;
`ifdef PRIORITY_BCD_ERR_CNT_EN
    logic [7:0]  cnt_a, cnt_b, cnt_c;
`endif

    priority_bcd_encoder #(.N_IN(10), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_d(in_d10), .in_valid(in_valid), .in_ready(rdy_a),
        .out_idx(idx_a), .out_bcd(bcd_a), .out_err(err_a), .out_valid(ov_a),
`ifdef PRIORITY_BCD_ERR_CNT_EN
        .err_cnt(cnt_a),
`endif
        .out_ready(out_ready));

    priority_bcd_encoder #(.N_IN(10), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_d(in_d10), .in_valid(in_valid), .in_ready(rdy_b),
        .out_idx(idx_b), .out_bcd(bcd_b), .out_err(err_b), .out_valid(ov_b),
`ifdef PRIORITY_BCD_ERR_CNT_EN
        .err_cnt(cnt_b),
`endif
        .out_ready(out_ready));

    priority_bcd_encoder #(.N_IN(64), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_d(in_d64), .in_valid(in_valid), .in_ready(rdy_c),
        .out_idx(idx_c), .out_bcd(bcd_c), .out_err(err_c), .out_valid(ov_c),
`ifdef PRIORITY_BCD_ERR_CNT_EN
        .err_cnt(cnt_c),
`endif
        .out_ready(out_ready));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct { int ia; int ib; int ic; int ea; int eb; int ec; } exp_t;
    exp_t q[$];

    // Reference: scan the request bits, count them, pick lowest or highest.
    function automatic void model(input logic [63:0] d, input int n, input bit msb,
                                  output int idx, output int err);
        int cnt = 0;
        int lo = 0;
        int hi = 0;
        for (int k = 0; k < n; k++) begin
            if (d[k]) begin
                if (cnt == 0) lo = k;
                hi = k;
                cnt++;
            end
        end
        idx = (cnt == 0) ? 0 : (msb ? hi : lo);
        err = (cnt == 0) ? 1 : ((cnt > 1) ? 2 : 0);
    endfunction

    function automatic int bcd_of(input int i);
        return (i / 10) * 16 + (i % 10);
    endfunction

    bit hold_pend = 1'b0;
    int snap_a = 0;
    int snap_c = 0;
    bit last_in_ready = 1'b0;
    int xfers = 0;
    int ecnt_a = 0;
    int ecnt_c = 0;

    // One clock cycle: drive, check handshakes against the scoreboard, step the clock.
    task automatic cycle(input bit v, input logic [9:0] d10, input logic [63:0] d64, input bit r);
        exp_t e;
        in_valid = v; in_d10 = d10; in_d64 = d64; out_ready = r;
        #2;
        if (!rst) begin
            if (hold_pend) begin
                chk("hold_a", int'({idx_a, bcd_a, err_a}), snap_a);
                chk("hold_c", int'({idx_c, bcd_c, err_c}), snap_c);
            end
            chk("in_ready_a", int'(rdy_a), int'((q.size() < 2) || r));
            chk("in_ready_b", int'(rdy_b), int'((q.size() < 2) || r));
            chk("in_ready_c", int'(rdy_c), int'((q.size() < 2) || r));
            last_in_ready = rdy_a;
            if (ov_a && q.size() == 0) chk("spurious_valid", int'(ov_a), 0);
            if (ov_a && r && q.size() > 0) begin
                e = q.pop_front();
                xfers++;
                chk("idx_a", int'(idx_a), e.ia);
                chk("bcd_a", int'(bcd_a), bcd_of(e.ia));
                chk("err_a", int'(err_a), e.ea);
                chk("idx_b", int'(idx_b), e.ib);
                chk("bcd_b", int'(bcd_b), bcd_of(e.ib));
                chk("err_b", int'(err_b), e.eb);
                chk("idx_c", int'(idx_c), e.ic);
                chk("bcd_c", int'(bcd_c), bcd_of(e.ic));
                chk("err_c", int'(err_c), e.ec);
                if (e.ea != 0 && ecnt_a < 255) ecnt_a++;
                if (e.ec != 0 && ecnt_c < 255) ecnt_c++;
            end
            hold_pend = ov_a && !r;
            snap_a = int'({idx_a, bcd_a, err_a});
            snap_c = int'({idx_c, bcd_c, err_c});
            if (v && rdy_a) begin
                model(64'(d10), 10, 1'b0, e.ia, e.ea);
                model(64'(d10), 10, 1'b1, e.ib, e.eb);
                model(d64, 64, 1'b0, e.ic, e.ec);
                q.push_back(e);
            end
        end else begin
            q.delete();
            hold_pend = 1'b0;
            ecnt_a = 0;
            ecnt_c = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out_valid"}, int'(ov_a), 0);
        chk({tag, "_out_idx"},   int'(idx_a), 0);
        chk({tag, "_out_bcd"},   int'(bcd_a), 0);
        chk({tag, "_out_err"},   int'(err_a), 0);
        chk({tag, "_in_ready"},  int'(rdy_a), 1);
    endtask

    function automatic logic [63:0] rnd_vec(input int n);
        logic [63:0] mask;
        int mode;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        mode = int'($urandom_range(0, 3));
        if (mode == 0) return 64'd0;
        if (mode == 1) return 64'd1 << $urandom_range(0, n - 1);
        return {$urandom, $urandom} & mask;
    endfunction

    typedef struct {
        logic [9:0]  d10;
        logic [63:0] d64;
        int ia; int ba; int ib; int bb; int e10;
        int ic; int bc; int ec;
    } vec_t;
    vec_t tv[5];

    initial begin
        int x0;
        tv[0] = '{10'b0000100000, 64'd1 << 47, 5, 8'h05, 5, 8'h05, 0, 47, 8'h47, 0};
        tv[1] = '{10'b1000000100, (64'd1 << 63) | (64'd1 << 10), 2, 8'h02, 9, 8'h09, 2, 10, 8'h10, 2};
        tv[2] = '{10'b0000000000, 64'd0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1};
        tv[3] = '{10'b1000000000, 64'd1 << 63, 9, 8'h09, 9, 8'h09, 0, 63, 8'h63, 0};
        tv[4] = '{10'b1111111111, 64'd1, 0, 8'h00, 9, 8'h09, 2, 0, 8'h00, 0};

        rst = 1'b1;
        cycle(1'b1, 10'h3ff, {64{1'b1}}, 1'b1);
        cycle(1'b0, 10'd0, 64'd0, 1'b1);
        rst = 1'b0;
        chk_cleared("reset");

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, tv[i].d10, tv[i].d64, 1'b1);
            chk("latency_early_valid", int'(ov_a), 0);
            cycle(1'b0, 10'd0, 64'd0, 1'b1);
            chk("latency_valid", int'(ov_a), 1);
            chk("tv_idx_a", int'(idx_a), tv[i].ia);
            chk("tv_bcd_a", int'(bcd_a), tv[i].ba);
            chk("tv_err_a", int'(err_a), tv[i].e10);
            chk("tv_idx_b", int'(idx_b), tv[i].ib);
            chk("tv_bcd_b", int'(bcd_b), tv[i].bb);
            chk("tv_err_b", int'(err_b), tv[i].e10);
            chk("tv_idx_c", int'(idx_c), tv[i].ic);
            chk("tv_bcd_c", int'(bcd_c), tv[i].bc);
            chk("tv_err_c", int'(err_c), tv[i].ec);
        end
        cycle(1'b0, 10'd0, 64'd0, 1'b1);

        // Back-pressure: three back-to-back requests, consumer stalled three cycles
        x0 = xfers;
        cycle(1'b1, 10'd1 << 1, 64'd1 << 1, 1'b0);
        cycle(1'b1, 10'd1 << 2, 64'd1 << 2, 1'b0);
        cycle(1'b1, 10'd1 << 3, 64'd1 << 3, 1'b0);
        chk("bp_in_ready_low", int'(last_in_ready), 0);
        chk("bp_out_held_idx", int'(idx_a), 1);
        cycle(1'b1, 10'd1 << 3, 64'd1 << 3, 1'b1);
        cycle(1'b0, 10'd0, 64'd0, 1'b1);
        cycle(1'b0, 10'd0, 64'd0, 1'b1);
        chk("bp_drained", q.size(), 0);
        chk("bp_xfer_count", xfers - x0, 3);

        // Reset with two items in flight, requests asserted during reset
        cycle(1'b1, 10'd1 << 4, 64'd1 << 4, 1'b0);
        cycle(1'b1, 10'd1 << 5, 64'd1 << 5, 1'b0);
        rst = 1'b1;
        cycle(1'b1, 10'h3ff, {64{1'b1}}, 1'b1);
        rst = 1'b0;
        chk_cleared("midrst");
        x0 = xfers;
        for (int i = 0; i < 4; i++) cycle(1'b0, 10'd0, 64'd0, 1'b1);
        chk("midrst_no_items", xfers - x0, 0);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 10'(rnd_vec(10)), rnd_vec(64),
                  1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 10; i++) begin
            if (q.size() > 0) cycle(1'b0, 10'd0, 64'd0, 1'b1);
        end
        chk("final_drain", q.size(), 0);

`ifdef PRIORITY_BCD_ERR_CNT_EN
        chk("err_cnt_a_rand", int'(cnt_a), ecnt_a);
        chk("err_cnt_c_rand", int'(cnt_c), ecnt_c);
        rst = 1'b1;
        cycle(1'b0, 10'd0, 64'd0, 1'b1);
        rst = 1'b0;
        chk("err_cnt_cleared", int'(cnt_a), 0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 10'd0, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 10'd0, 64'd0, 1'b1);
        chk("err_cnt_a_sat", int'(cnt_a), 255);
        chk("err_cnt_b_sat", int'(cnt_b), 255);
        chk("err_cnt_c_sat", int'(cnt_c), 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_bcd_encoder.md
PRIORITY_BCD_ENCODER -- requirements
Module: priority_bcd_encoder

Interface
REQ-001 SHALL have parameter N_IN, default 10: number of request lines, legal range 2..100.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = lowest set bit wins, 1 = highest set bit wins.
REQ-003 SHALL have localparam IDX_W = $clog2(N_IN), the binary index width.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_d, input, N_IN: request vector, bit k = request k.
REQ-007 SHALL have port in_valid, input, 1: in_d valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: stage 1 can accept this cycle.
REQ-009 SHALL have port out_idx, output, IDX_W: binary index of the winning bit.
REQ-010 SHALL have port out_bcd, output, 8: [7:4] tens digit, [3:0] units digit of out_idx.
REQ-011 SHALL have port out_err, output, 2: 00 ok, 01 no bit set, 10 multiple bits set.
REQ-012 SHALL have port out_valid, output, 1: out_* valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts.

Function
REQ-014 SHALL form a 2-stage pipeline: stage 1 registers the index and error code, stage 2 registers the BCD conversion; latency 2 cycles from accepted input to out_valid.
REQ-015 SHALL accept input only when in_valid && in_ready, and transfer output only when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready; sustained throughput 1 per cycle when out_ready=1.
REQ-017 SHALL hold out_idx, out_bcd and out_err stable while out_valid && !out_ready.
REQ-018 SHALL, for exactly one set bit k, output idx=k, err=00.
REQ-019 SHALL, for zero set bits, output idx=0, bcd=8'h00, err=01.
REQ-020 SHALL, for multiple set bits, output the index selected by MSB_FIRST, with err=10.
REQ-021 SHALL produce BCD digits each in the range 0..9, tens = idx/10 and units = idx%10.
REQ-022 SHALL accept a new input in the same cycle the stage-1 holder moves to stage 2, with no bubble.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, clear s1_valid and out_valid to 0, out_idx to 0, out_bcd to 8'h00, and out_err to 00.
REQ-024 SHALL, when rst is asserted mid-operation, discard all in-flight items; in_ready = 1 in the first cycle after rst deasserts.
REQ-025 SHALL ignore in_valid while rst=1.

Configuration
REQ-026 SHALL, with macro PRIORITY_BCD_ERR_CNT_EN defined, add output err_cnt [7:0]: increments on each output transfer with err != 00, saturates at 255, cleared by rst.
REQ-027 SHALL, with PRIORITY_BCD_ERR_CNT_EN undefined, have no err_cnt port and no counter logic.

Structure
REQ-028 SHALL place in shared package bcd_pkg: typedef bcd_digit_t (4 bits), enum err_code_t (ERR_OK, ERR_NONE, ERR_MULTI), and constant BCD_MAX_IDX = 99.
REQ-029 SHALL implement the index-to-BCD conversion in sub-module bin2bcd_2dig: combinational, 7-bit input, two bcd_digit_t outputs.

Verification
REQ-030 SHALL cover: N_IN=10, in_d=10'b0000100000, out_ready=1 -> two cycles later idx=5, bcd=8'h05, err=00.
REQ-031 SHALL cover: N_IN=64, in_d bit 47 set -> idx=47, bcd=8'h47, err=00.
REQ-032 SHALL cover: N_IN=10, in_d=10'b1000000100 -> MSB_FIRST=0 gives idx=2 and MSB_FIRST=1 gives idx=9, err=10 in both; and in_d=0 -> idx=0, err=01.
REQ-033 SHALL cover: back-to-back inputs 1,2,3 with out_ready low for 3 cycles -> in_ready=0 after 2 accepts, outputs held, then drained in order 1,2,3 with no loss or duplication.
REQ-034 SHALL cover: rst pulsed with 2 items in flight -> out_valid=0 next cycle, and no item appears afterward.
REQ-035 SHALL cover: with PRIORITY_BCD_ERR_CNT_EN defined, 300 zero-hot inputs -> err_cnt=255.
